eth_tx_min_frame_padder: RTL and testbench
==========================================

Name: eth_tx_min_frame_padder

Overview:
Sits directly downstream of the Ethernet IPv4 interface's eth_tx port and upstream of the 10/25/100G MAC TX.
Pads any outgoing frame shorter than the Ethernet minimum (60 bytes excluding FCS) with zero bytes, so the MAC never emits runts.
Frames at or above the minimum pass through unmodified.
Single-stage registered AXI-Stream pipeline with a pad-insertion state machine.

Parameters:
DATA_W, 64, AXI-Stream data width in bits; only 64 is supported.
MIN_BYTES, 60, minimum frame length in bytes before FCS; legal range 9..248.

Ports:
clk  input  1  clock, shared by both stream ports
rst  input  1  reset; asynchronous, active-high
i_tdata  input  64  frame data from the IPv4 interface; byte 0 in bits [7:0]
i_tuser  input  4  {error, trailing_bytes[2:0]}; trailing_bytes 0 means all 8 valid; meaningful only on tlast
i_tlast  input  1  last beat of frame
i_tvalid  input  1  input valid
i_tready  output  1  input ready
o_tdata  output  64  padded frame data to the MAC
o_tuser  output  4  {error, trailing_bytes}, same encoding as i_tuser
o_tlast  output  1  last beat of frame
o_tvalid  output  1  output valid
o_tready  input  1  MAC ready
pad_count  output  32  count of padded frames (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high): o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0, pad_count=0, state=ST_PASS, beat_cnt=0.
- Pipeline:
  - Output register is loaded when (!o_tvalid || o_tready).
  - Latency is 1 cycle from input handshake to o_tvalid.
  - No combinational path from i_tvalid to o_tvalid.
  - o_tready feeds i_tready combinationally.
- i_tready = (!o_tvalid || o_tready) && state==ST_PASS.
- beat_cnt counts accepted beats of the current frame.
  - It saturates at MIN_BEATS = ceil(MIN_BYTES/8) (8 for the default).
  - It clears on the input tlast handshake.
- Frame length on tlast: len = beat_cnt*8 + (tb==0 ? 8 : tb), where tb = i_tuser[2:0].
- ST_PASS, non-last beat: forward data and tuser unchanged.
- ST_PASS, tlast beat with len >= MIN_BYTES: forward unchanged; stay in ST_PASS.
- ST_PASS, tlast beat with len < MIN_BYTES and beat_cnt == MIN_BEATS-1:
  - Pad inside the same beat: lanes >= tb are zeroed (tb==0 means no lanes are zeroed).
  - o_tlast=1, o_tuser = {error, MIN_BYTES%8}.
  - Stay in ST_PASS.
- ST_PASS, tlast beat with len < MIN_BYTES and beat_cnt < MIN_BEATS-1:
  - Forward with invalid lanes zeroed, o_tlast=0, o_tuser=0.
  - Latch error into err_q, set pad_beat = beat_cnt+1, go to ST_PAD.
- ST_PAD, on each output load:
  - Emit an all-zero beat and increment pad_beat.
  - When pad_beat == MIN_BEATS-1: o_tlast=1, o_tuser = {err_q, MIN_BYTES%8}, return to ST_PASS.
- The error bit is preserved onto the final output beat whether or not padding occurs.
- pad_count increments by 1 on the cycle a padded final beat is loaded.
  - Padded means len < MIN_BYTES, including same-beat padding.
  - The counter saturates at 2^32-1.
- Reset mid-frame: the output frame is truncated with no tlast. The upstream is required to restart at a frame boundary after reset; no recovery logic.
- Output stall (o_tready=0) in any state: output register and state hold; i_tready=0.

Optional Feature:
Macro ETH_TX_PAD_STATS_EN.
- Defined: pad_count is implemented as specified.
- Undefined: pad_count is tied to 32'd0 and the counter logic is omitted. Data-path behaviour is identical.

Decomposition:
- Package eth_tx_pkg holds:
  - ETH_MIN_FRAME_BYTES = 60
  - typedef enum logic {ST_PASS, ST_PAD} pad_state_t
  - packed struct eth_tuser_t {logic error; logic [2:0] trailing;}
  - function lane_mask(trailing) returning the 64-bit keep mask
- No sub-module is needed; a single module is the natural structure.

Test Plan:
- 64-byte frame (8 beats, tb=0) with o_tready=1 → identical 8 beats out, 1-cycle latency, pad_count unchanged.
- 14-byte frame (2 beats, tb=6) → 8 beats out; beat 1 has bytes 6..7 zeroed; beats 2..7 are zero; last beat tb=4; pad_count=1.
- 57-byte frame (8 beats, last tb=1) → 8 beats out; last beat tb=4 with lanes 1..3 zeroed; pad_count=1.
- 42-byte frame with error=1 and random o_tready backpressure (50%) → 8 beats out; error=1 only on the final beat; no data loss; i_tready low during ST_PAD.
- Back-to-back 20-byte frame then 100-byte frame → the second frame starts the cycle after the pad tlast and passes through unmodified; pad_count=1.
- rst asserted during the 3rd pad beat → o_tvalid=0 asynchronously, pad_count=0; next 60-byte frame passes through unmodified.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and helpers for the Ethernet TX minimum-frame padder.
// Holds the minimum frame length, pad FSM states, tuser layout and lane-mask helper.
// No logic of its own; imported by eth_tx_min_frame_padder.
package eth_tx_pkg;

    // Ethernet minimum frame length in bytes, excluding FCS.
    localparam int ETH_MIN_FRAME_BYTES = 60;

    typedef enum logic {ST_PASS, ST_PAD} pad_state_t;

    typedef struct packed {
        logic       error;
        logic [2:0] trailing;
    } eth_tuser_t;

    // Byte-lane keep mask for a final beat; trailing 0 means all 8 lanes are valid.
    function automatic logic [63:0] lane_mask(input logic [2:0] trailing);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (trailing == 3'd0 || i < int'(trailing)) begin
                mask[i*8 +: 8] = 8'hFF;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/eth_tx_min_frame_padder.sv
// Pads short Ethernet TX frames with zero bytes up to MIN_BYTES; longer frames pass unmodified.
// Latency: 1 cycle, single registered AXI-Stream stage; pad beats follow the short frame's last data beat.
// Backpressure: i_tready = output load enable while passing; held low while pad beats are emitted.
// Optional pad statistics counter enabled by defining ETH_TX_PAD_STATS_EN.
module eth_tx_min_frame_padder
    import eth_tx_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MIN_BYTES = ETH_MIN_FRAME_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic [3:0]        i_tuser,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic [3:0]        o_tuser,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [31:0]       pad_count
);

    localparam int         MIN_BEATS = (MIN_BYTES + 7) / 8;
    localparam logic [4:0] LAST_BEAT = 5'(MIN_BEATS - 1);
    localparam logic [4:0] SAT_BEATS = 5'(MIN_BEATS);
    localparam logic [2:0] MIN_TRAIL = 3'(MIN_BYTES % 8);
    localparam logic [9:0] MIN_LEN   = 10'(MIN_BYTES);

    pad_state_t  state;
    logic [4:0]  beat_cnt;
    logic [4:0]  pad_beat;
    logic        err_q;

    eth_tuser_t  in_user;
    logic        load;
    logic [3:0]  tail_bytes;
    logic [9:0]  frame_len;
    logic        short_frame;

    assign in_user     = eth_tuser_t'(i_tuser);
    assign load        = !o_tvalid || o_tready;
    assign i_tready    = load && (state == ST_PASS);
    assign tail_bytes  = (in_user.trailing == 3'd0) ? 4'd8 : {1'b0, in_user.trailing};
    // Only meaningful on the tlast beat; beat_cnt saturation keeps long frames above MIN_LEN.
    assign frame_len   = {2'b00, beat_cnt, 3'b000} + {6'd0, tail_bytes};
    assign short_frame = frame_len < MIN_LEN;

    // Output register plus pad FSM: forward, pad in the same beat, or append zero beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tuser  <= '0;
            o_tlast  <= 1'b0;
            state    <= ST_PASS;
            beat_cnt <= '0;
            pad_beat <= '0;
            err_q    <= 1'b0;
        end else if (load) begin
            if (state == ST_PASS) begin
                // In ST_PASS i_tready equals load, so i_tvalid alone marks a handshake.
                o_tvalid <= i_tvalid;
                if (i_tvalid) begin
                    if (!i_tlast) begin
                        o_tdata <= i_tdata;
                        o_tuser <= i_tuser;
                        o_tlast <= 1'b0;
                        if (beat_cnt != SAT_BEATS) begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end else begin
                        beat_cnt <= '0;
                        if (!short_frame) begin
                            o_tdata <= i_tdata;
                            o_tuser <= i_tuser;
                            o_tlast <= 1'b1;
                        end else if (beat_cnt == LAST_BEAT) begin
                            o_tdata <= i_tdata & lane_mask(in_user.trailing);
                            o_tuser <= {in_user.error, MIN_TRAIL};
                            o_tlast <= 1'b1;
                        end else begin
                            o_tdata  <= i_tdata & lane_mask(in_user.trailing);
                            o_tuser  <= '0;
                            o_tlast  <= 1'b0;
                            err_q    <= in_user.error;
                            pad_beat <= beat_cnt + 5'd1;
                            state    <= ST_PAD;
                        end
                    end
                end
            end else begin
                o_tvalid <= 1'b1;
                o_tdata  <= '0;
                pad_beat <= pad_beat + 5'd1;
                if (pad_beat == LAST_BEAT) begin
                    o_tlast <= 1'b1;
                    o_tuser <= {err_q, MIN_TRAIL};
                    state   <= ST_PASS;
                end else begin
                    o_tlast <= 1'b0;
                    o_tuser <= '0;
                end
            end
        end
    end

`ifdef ETH_TX_PAD_STATS_EN
    logic pad_done;

    assign pad_done = load &&
        (((state == ST_PASS) && i_tvalid && i_tlast && short_frame && (beat_cnt == LAST_BEAT)) ||
         ((state == ST_PAD) && (pad_beat == LAST_BEAT)));

    // Count frames whose final beat was padded, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_count <= '0;
        end else if (pad_done && (pad_count != 32'hFFFF_FFFF)) begin
            pad_count <= pad_count + 32'd1;
        end
    end
`else
    assign pad_count = 32'd0;
`endif

endmodule

// File: tb/tb_eth_tx_min_frame_padder.sv
// Self-checking bench for eth_tx_min_frame_padder with a byte-level padding reference model.
// Drives randomized frames with optional valid gaps and output backpressure.
// Expected pad_count depends on whether ETH_TX_PAD_STATS_EN is defined.
module tb_eth_tx_min_frame_padder;

    localparam int MIN_BYTES = 60;
`ifdef ETH_TX_PAD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] i_tdata = '0;
    logic [3:0]  i_tuser = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic [3:0]  o_tuser;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [31:0] pad_count;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit bp = 1'b0;
    bit gaps = 1'b0;
    bit watch_pad = 1'b0;
    int rdy_in_pad = 0;
    int exp_pads = 0;

    // Beats are packed as {last, tuser[3:0], data[63:0]}.
    logic [68:0] in_q[$];
    logic [68:0] exp_q[$];
    logic [68:0] obs_q[$];
    int          obs_cyc[$];
    int          hs_cyc[$];

    eth_tx_min_frame_padder dut (
        .clk       (clk),
        .rst       (rst),
        .i_tdata   (i_tdata),
        .i_tuser   (i_tuser),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tuser   (o_tuser),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .pad_count (pad_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        o_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor, sampled mid-cycle; also watches i_tready while pad beats are pending.
    initial forever begin
        @(negedge clk);
        if (!rst && o_tvalid && o_tready) begin
            obs_q.push_back({o_tlast, o_tuser, o_tdata});
            obs_cyc.push_back(cyc);
        end
        if (watch_pad) begin
            if (o_tvalid && o_tlast) watch_pad = 1'b0;
            else if (i_tready) rdy_in_pad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int exp_pc();
        return STATS ? exp_pads : 0;
    endfunction

    function automatic logic [68:0] obs_at(input int k);
        if (k < obs_q.size()) return obs_q[k];
        return 'x;
    endfunction

    // Reference model: a short frame becomes its bytes followed by zeros up to MIN_BYTES.
    task automatic add_frame(input int len, input bit err);
        logic [7:0]  fb[$];
        logic [63:0] w;
        logic [3:0]  u;
        int          nb;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            w = {$urandom, $urandom};
            u = (b == nb - 1) ? {err, 3'(len % 8)} : 4'h0;
            in_q.push_back({b == nb - 1, u, w});
            if (len >= MIN_BYTES) exp_q.push_back({b == nb - 1, u, w});
            for (int l = 0; l < 8; l++) if (b * 8 + l < len) fb.push_back(w[l*8 +: 8]);
        end
        if (len < MIN_BYTES) begin
            while (fb.size() < MIN_BYTES) fb.push_back(8'h00);
            nb = (MIN_BYTES + 7) / 8;
            for (int b = 0; b < nb; b++) begin
                w = '0;
                for (int l = 0; l < 8; l++) if (b * 8 + l < MIN_BYTES) w[l*8 +: 8] = fb[b*8 + l];
                u = (b == nb - 1) ? {err, 3'(MIN_BYTES % 8)} : 4'h0;
                exp_q.push_back({b == nb - 1, u, w});
            end
            exp_pads++;
        end
    endtask

    task automatic drive_all();
        logic [68:0] beat;
        bit          hs;
        int          n;
        while (in_q.size() > 0) begin
            beat = in_q.pop_front();
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            i_tvalid = 1'b1;
            i_tlast  = beat[68];
            i_tuser  = beat[67:64];
            i_tdata  = beat[63:0];
            n = 0;
            forever begin
                @(negedge clk);
                hs = i_tready;
                if (hs) hs_cyc.push_back(cyc);
                @(posedge clk);
                #1;
                if (hs) break;
                n++;
                if (n > 1000) begin
                    checks++;
                    $display("FAIL drive_timeout: i_tready low for %0d cycles, required a handshake", n);
                    in_q.delete();
                    break;
                end
            end
            i_tvalid = 1'b0;
            i_tlast  = 1'b0;
        end
    endtask

    task automatic run_traffic(input string name);
        int n;
        n = 0;
        obs_q.delete();
        obs_cyc.delete();
        hs_cyc.delete();
        rdy_in_pad = 0;
        drive_all();
        watch_pad = 1'b1;
        while (obs_q.size() < exp_q.size() && n < 4000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        watch_pad = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL %s beat_count: got %0d beats, required %0d", name, obs_q.size(), exp_q.size());
        else passes++;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_tvalid !== 1'b0) $display("FAIL reset_o_tvalid: got %b, required 0", o_tvalid); else passes++;
        checks++; if (o_tdata !== 64'd0) $display("FAIL reset_o_tdata: got %h, required 0", o_tdata); else passes++;
        checks++; if (o_tuser !== 4'd0) $display("FAIL reset_o_tuser: got %h, required 0", o_tuser); else passes++;
        checks++; if (o_tlast !== 1'b0) $display("FAIL reset_o_tlast: got %b, required 0", o_tlast); else passes++;
        checks++; if (pad_count !== 32'd0) $display("FAIL reset_pad_count: got %0d, required 0", pad_count); else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (i_tready !== 1'b1) $display("FAIL reset_i_tready: got %b, required 1", i_tready); else passes++;
    endtask

    task automatic test_full_frame();
        bp = 1'b0; gaps = 1'b0;
        add_frame(64, 1'b0);
        run_traffic("full64");
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_at(k) !== exp_q[k]) $display("FAIL full64 beat%0d: got %h, required %h", k, obs_at(k), exp_q[k]);
            else passes++;
        end
        checks++;
        if (obs_cyc.size() == 0 || hs_cyc.size() == 0 || obs_cyc[0] != hs_cyc[0] + 1)
            $display("FAIL full64 latency: got output at cycle %0d, required %0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, (hs_cyc.size() > 0) ? hs_cyc[0] + 1 : -1);
        else passes++;
        checks++; if (pad_count !== 32'(exp_pc())) $display("FAIL full64 pad_count: got %0d, required %0d", pad_count, exp_pc()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_short_frame();
        bp = 1'b0; gaps = 1'b0;
        add_frame(14, 1'b0);
        run_traffic("short14");
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_at(k) !== exp_q[k]) $display("FAIL short14 beat%0d: got %h, required %h", k, obs_at(k), exp_q[k]);
            else passes++;
        end
        checks++; if (rdy_in_pad != 0) $display("FAIL short14 i_tready_in_pad: got %0d ready cycles, required 0", rdy_in_pad); else passes++;
        checks++; if (pad_count !== 32'(exp_pc())) $display("FAIL short14 pad_count: got %0d, required %0d", pad_count, exp_pc()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_same_beat_pad();
        bp = 1'b0; gaps = 1'b0;
        add_frame(57, 1'b0);
        run_traffic("same57");
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_at(k) !== exp_q[k]) $display("FAIL same57 beat%0d: got %h, required %h", k, obs_at(k), exp_q[k]);
            else passes++;
        end
        checks++; if (pad_count !== 32'(exp_pc())) $display("FAIL same57 pad_count: got %0d, required %0d", pad_count, exp_pc()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_error_backpressure();
        bp = 1'b1; gaps = 1'b0;
        add_frame(42, 1'b1);
        run_traffic("err42");
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_at(k) !== exp_q[k]) $display("FAIL err42 beat%0d: got %h, required %h", k, obs_at(k), exp_q[k]);
            else passes++;
        end
        checks++; if (rdy_in_pad != 0) $display("FAIL err42 i_tready_in_pad: got %0d ready cycles, required 0", rdy_in_pad); else passes++;
        checks++; if (pad_count !== 32'(exp_pc())) $display("FAIL err42 pad_count: got %0d, required %0d", pad_count, exp_pc()); else passes++;
        exp_q.delete();
        bp = 1'b0;
    endtask

    task automatic test_back_to_back();
        bp = 1'b0; gaps = 1'b0;
        add_frame(20, 1'b0);
        add_frame(100, 1'b0);
        run_traffic("b2b");
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_at(k) !== exp_q[k]) $display("FAIL b2b beat%0d: got %h, required %h", k, obs_at(k), exp_q[k]);
            else passes++;
        end
        checks++;
        if (obs_cyc.size() < 9 || obs_cyc[8] != obs_cyc[7] + 1)
            $display("FAIL b2b gap: got second frame at cycle %0d, required %0d", (obs_cyc.size() > 8) ? obs_cyc[8] : -1, (obs_cyc.size() > 7) ? obs_cyc[7] + 1 : -1);
        else passes++;
        checks++; if (pad_count !== 32'(exp_pc())) $display("FAIL b2b pad_count: got %0d, required %0d", pad_count, exp_pc()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_boundaries_random();
        int lens[8];
        lens = '{1, 8, 52, 56, 59, 60, 61, 9};
        bp = 1'b1; gaps = 1'b1;
        foreach (lens[i]) add_frame(lens[i], 1'($urandom_range(0, 1)));
        for (int i = 0; i < 12; i++) add_frame($urandom_range(1, 140), 1'($urandom_range(0, 1)));
        run_traffic("rand");
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_at(k) !== exp_q[k]) $display("FAIL rand beat%0d: got %h, required %h", k, obs_at(k), exp_q[k]);
            else passes++;
        end
        checks++; if (pad_count !== 32'(exp_pc())) $display("FAIL rand pad_count: got %0d, required %0d", pad_count, exp_pc()); else passes++;
        exp_q.delete();
        bp = 1'b0; gaps = 1'b0;
    endtask

    task automatic test_reset_mid_pad();
        int n;
        n = 0;
        bp = 1'b0; gaps = 1'b0;
        obs_q.delete();
        add_frame(14, 1'b0);
        drive_all();
        // Output beats 2.. are pad beats; the third pad beat is loaded once beat 3 has left.
        while (obs_q.size() < 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (o_tvalid !== 1'b0) $display("FAIL rstpad o_tvalid: got %b, required 0", o_tvalid); else passes++;
        checks++; if (o_tlast !== 1'b0) $display("FAIL rstpad o_tlast: got %b, required 0", o_tlast); else passes++;
        checks++; if (pad_count !== 32'd0) $display("FAIL rstpad pad_count: got %0d, required 0", pad_count); else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        in_q.delete();
        exp_pads = 0;
        @(posedge clk);
        #1;
        add_frame(60, 1'b0);
        run_traffic("after_rst60");
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_at(k) !== exp_q[k]) $display("FAIL after_rst60 beat%0d: got %h, required %h", k, obs_at(k), exp_q[k]);
            else passes++;
        end
        checks++; if (pad_count !== 32'(exp_pc())) $display("FAIL after_rst60 pad_count: got %0d, required %0d", pad_count, exp_pc()); else passes++;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_same_beat_pad();
        test_error_backpressure();
        test_back_to_back();
        test_boundaries_random();
        test_reset_mid_pad();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
